mem_unit: RTL and testbench
===========================

Name: mem_unit

Overview:
- Memory execution unit that services the thread's memory requests (instruction fetch, and later loads and stores) on the shared unit bus.
- Sits directly downstream of the thread. Its rdata feeds the unit_out mux whenever unit_sel == UNIT_SEL_MEM.
- Word-organised synchronous RAM. Fixed 1-cycle read latency, so no ready handshake is needed.
- Supports byte, half and word access with sign/zero extension, plus a sticky misalignment fault record.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of 2. Address bits used: [log2(DEPTH_WORDS)+1:0].
- INIT_FILE, "", hex image loaded by $readmemh at elaboration; empty string means no load.

Ports:
- clk  input  1  clock
- rst  input  1  reset: asynchronous, active-high
- unit_sel  input  unit_sel_t  request is valid only when == UNIT_SEL_MEM
- unit_ctrl  input  32  [1:0] size (0=byte, 1=half, 2=word, 3=reserved); [2] unsigned load; [3] write; [31:4] ignored. MEM_CTRL_READ = 0x2.
- addr  input  32  byte address (unit_in[0])
- wdata  input  32  store data, LSB-aligned (unit_in[1])
- rdata  output  32  load result for the previous cycle's read request
- fault  output  1  sticky: a misaligned or reserved-size access occurred
- fault_addr  output  32  address of the first faulting access
- fault_clr  input  1  synchronous clear of fault and fault_addr

Behaviour:
- Reset values: rdata=0, fault=0, fault_addr=0. RAM contents are not reset.
- Request definition: req = (unit_sel == UNIT_SEL_MEM). Outside req, RAM, rdata and fault are all held.
- Read (req & !ctrl[3]) at edge N:
  - RAM word addr[..:2] is read.
  - rdata is valid after edge N+1 and holds until the next read request.
  - This matches the thread's two fetch cycles with an identical address.
- Load formatting is registered together with the data:
  - byte lane = addr[1:0]; half lane = addr[1].
  - Result is sign-extended, or zero-extended if ctrl[2]=1.
  - Word access ignores ctrl[2].
- Write (req & ctrl[3]) at edge N:
  - Byte enables: byte = 1 << addr[1:0]; half = 0b11 << addr[1]*2; word = 0b1111.
  - wdata is replicated into the lanes (byte into all 4, half into both).
  - The write does not update rdata.
- Read-after-write: a read issued in the cycle after a write to the same word returns the new data. This falls out naturally from synchronous RAM; no forwarding path is needed.
- Misaligned access: half with addr[0]=1, word with addr[1:0]!=0, or size=3.
  - The access is suppressed: no RAM write, and rdata is loaded with 0.
  - If fault==0, then fault<=1 and fault_addr<=addr. A later fault does not overwrite fault_addr.
- fault_clr is sampled on the same edge as a new fault: clear wins, and fault stays 0 for that edge.
- Address wrap: upper address bits are ignored, so the address is taken modulo 4*DEPTH_WORDS.
- Reset mid-operation: an in-flight read is discarded and rdata=0. A write on the reset edge is not performed.

Optional Feature:
- Macro: MEM_UNIT_BOUNDS_EN.
- Defined:
  - Any addr >= 4*DEPTH_WORDS is treated as a fault: access suppressed, rdata=0, fault/fault_addr recorded.
  - Wrap-around is disabled.
- Undefined: addresses wrap modulo the RAM size and no bounds logic is synthesised.

Test Plan:
1. Reset, then write word 0xDEADBEEF at 0x10 (ctrl=0xA); read 0x10 (ctrl=0x2) for 2 cycles -> rdata=0 in the request cycle, 0xDEADBEEF after the second edge, held while unit_sel=NONE.
2. Byte loads from 0x10: addr 0x13 ctrl=0x0 -> 0xFFFFFFDE; ctrl=0x4 -> 0x000000DE. Half load at 0x12 ctrl=0x1 -> 0xFFFFDEAD; ctrl=0x5 -> 0x0000DEAD.
3. SB 0x55 at 0x11 (ctrl=0x8) followed by a word read of 0x10 the next cycle -> 0xDEAD55EF, confirming byte enable and read-after-write.
4. Misalignment: word read at 0x21 -> rdata=0, fault=1, fault_addr=0x21. Half write at 0x33 -> RAM unchanged, fault_addr stays 0x21. Then fault_clr=1 -> fault=0, fault_addr=0.
5. Wrap, DEPTH_WORDS=1024: write 0x12345678 to 0x1004, read 0x4 -> 0x12345678. With MEM_UNIT_BOUNDS_EN: the write is suppressed, fault=1, fault_addr=0x1004.
6. Assert rst during the cycle after a read request to a word holding 0xCAFEF00D -> rdata=0 immediately; after release, a fetch sequence reproduces 0xCAFEF00D.

Source files
------------

// File: rtl/mem_unit.sv
// Memory execution unit: word-organised synchronous RAM with byte/half/word loads and stores.
// Define MEM_UNIT_BOUNDS_EN to fault on addresses past the end of the RAM instead of wrapping.
module mem_unit #(
    parameter int unsigned           DEPTH_WORDS  = 1024,
    parameter string                 INIT_FILE    = "",
    parameter int unsigned           UNIT_SEL_W   = 3,
    parameter logic [UNIT_SEL_W-1:0] UNIT_SEL_MEM = UNIT_SEL_W'(2)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [UNIT_SEL_W-1:0] i_unit_sel,
    input  logic [31:0]           i_unit_ctrl,
    input  logic [31:0]           i_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata,
    output logic                  o_fault,
    output logic [31:0]           o_fault_addr,
    input  logic                  i_fault_clr
);
    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam int unsigned ADDR_W = IDX_W + 2;

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;
    logic [31:0] r_fault_addr;
    logic        r_fault;

    logic             w_req;
    logic             w_write;
    logic             w_unsigned;
    logic [1:0]       w_size;
    logic             w_misalign;
    logic             w_oob;
    logic             w_bad;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_word;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load;
    logic [31:0]      w_wdata;
    logic [3:0]       w_be;
    logic             w_unused;

    assign w_req      = (i_unit_sel == UNIT_SEL_MEM);
    assign w_size     = i_unit_ctrl[1:0];
    assign w_unsigned = i_unit_ctrl[2];
    assign w_write    = i_unit_ctrl[3];
    assign w_misalign = (w_size == 2'd3)
                     || ((w_size == 2'd1) && i_addr[0])
                     || ((w_size == 2'd2) && (i_addr[1:0] != 2'b00));
`ifdef MEM_UNIT_BOUNDS_EN
    assign w_oob      = |i_addr[31:ADDR_W];
`else
    assign w_oob      = 1'b0;
`endif
    assign w_bad      = w_misalign | w_oob;
    assign w_unused   = ^{i_unit_ctrl[31:4], i_addr[31:ADDR_W]};

    assign w_idx  = i_addr[ADDR_W-1:2];
    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{i_addr[1:0], 3'b000} +: 8];
    assign w_half = w_word[{i_addr[1], 4'b0000} +: 16];

    // Load extension, store byte enables and lane replication per access size.
    always_comb begin
        w_load  = w_word;
        w_be    = 4'b1111;
        w_wdata = i_wdata;
        case (w_size)
            2'd0: begin
                w_load  = {{24{w_byte[7] & ~w_unsigned}}, w_byte};
                w_be    = 4'b0001 << i_addr[1:0];
                w_wdata = {4{i_wdata[7:0]}};
            end
            2'd1: begin
                w_load  = {{16{w_half[15] & ~w_unsigned}}, w_half};
                w_be    = 4'b0011 << {i_addr[1], 1'b0};
                w_wdata = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && w_req && w_write && !w_bad) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata      <= 32'h0;
            r_fault      <= 1'b0;
            r_fault_addr <= 32'h0;
        end else begin
            if (w_req && (w_bad || !w_write)) begin
                r_rdata <= w_bad ? 32'h0 : w_load;
            end
            // Clear beats a fault arriving on the same edge.
            if (i_fault_clr) begin
                r_fault      <= 1'b0;
                r_fault_addr <= 32'h0;
            end else if (w_req && w_bad && !r_fault) begin
                r_fault      <= 1'b1;
                r_fault_addr <= i_addr;
            end
        end
    end

    assign o_rdata      = r_rdata;
    assign o_fault      = r_fault;
    assign o_fault_addr = r_fault_addr;

endmodule

// File: tb/tb_mem_unit.sv
// Scoreboard bench for mem_unit: directed scenarios plus random traffic against a byte-array model.
module tb_mem_unit;
    localparam int unsigned DEPTH    = 1024;
    localparam int unsigned BYTES    = 4 * DEPTH;
    localparam logic [2:0]  SEL_NONE = 3'd0;
    localparam logic [2:0]  SEL_MEM  = 3'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  unit_sel = SEL_NONE;
    logic [31:0] unit_ctrl = 32'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        fault_clr = 1'b0;
    logic [31:0] rdata;
    logic        fault;
    logic [31:0] fault_addr;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        logic [31:0] faddr;
        int          id;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          op_id    = 0;
    logic [7:0]  mb [BYTES];
    logic [31:0] m_rdata = 32'h0;
    logic [31:0] m_faddr = 32'h0;
    logic        m_fault = 1'b0;

    mem_unit #(
        .DEPTH_WORDS (DEPTH),
        .INIT_FILE   (""),
        .UNIT_SEL_W  (3),
        .UNIT_SEL_MEM(SEL_MEM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_unit_sel  (unit_sel),
        .i_unit_ctrl (unit_ctrl),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_rdata     (rdata),
        .o_fault     (fault),
        .o_fault_addr(fault_addr),
        .i_fault_clr (fault_clr)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input int id,
                                  input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (op %0d): got %h, expected %h", name, id, act, exp);
        end
    endfunction

    // Byte-addressed reference: an access is n = 2**size little-endian bytes at addr.
    function automatic void model_step(input logic [2:0] sel, input logic [31:0] ctrl,
                                       input logic [31:0] a_in, input logic [31:0] wd,
                                       input logic clr);
        int unsigned n;
        int unsigned a;
        logic        bad;
        logic [31:0] v;
        if (rst) begin
            m_rdata = 32'h0;
            m_fault = 1'b0;
            m_faddr = 32'h0;
            return;
        end
        n   = 1 << ctrl[1:0];
        bad = (ctrl[1:0] == 2'd3) || ((a_in % n) != 0);
`ifdef MEM_UNIT_BOUNDS_EN
        bad = bad || (a_in >= BYTES);
`endif
        a = a_in % BYTES;
        if (sel == SEL_MEM) begin
            if (bad) begin
                m_rdata = 32'h0;
            end else if (ctrl[3]) begin
                for (int k = 0; k < int'(n); k++) mb[a + k] = wd[8*k +: 8];
            end else begin
                v = 32'h0;
                for (int k = 0; k < int'(n); k++) v[8*k +: 8] = mb[a + k];
                if (n < 4 && !ctrl[2] && v[8*n - 1]) begin
                    for (int k = 8 * int'(n); k < 32; k++) v[k] = 1'b1;
                end
                m_rdata = v;
            end
        end
        if (clr) begin
            m_fault = 1'b0;
            m_faddr = 32'h0;
        end else if (sel == SEL_MEM && bad && !m_fault) begin
            m_fault = 1'b1;
            m_faddr = a_in;
        end
    endfunction

    task automatic do_op(input logic [2:0] sel, input logic [31:0] ctrl,
                         input logic [31:0] a_in, input logic [31:0] wd, input logic clr);
        unit_sel  = sel;
        unit_ctrl = ctrl;
        addr      = a_in;
        wdata     = wd;
        fault_clr = clr;
        op_id++;
        model_step(sel, ctrl, a_in, wd, clr);
        @(posedge clk);
        q.push_back('{rdata: m_rdata, fault: m_fault, faddr: m_faddr, id: op_id});
        #1;
    endtask

    // Monitor: one expected state per clock edge, compared on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("rdata", e.id, rdata, e.rdata);
                check("fault", e.id, {31'b0, fault}, {31'b0, e.fault});
                check("fault_addr", e.id, fault_addr, e.faddr);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ctrl;
        logic [31:0] a;
        logic [1:0]  size;
        logic [2:0]  sel;
        int          r;

        do_op(SEL_NONE, 32'h0, 32'h0, 32'h0, 1'b0);
        do_op(SEL_MEM, 32'h2, 32'h0, 32'h0, 1'b0);
        rst = 1'b0;

        // Give every word a known value so no read depends on uninitialised RAM.
        for (int i = 0; i < int'(DEPTH); i++) do_op(SEL_MEM, 32'hA, 32'(i * 4), $urandom, 1'b0);

        do_op(SEL_MEM, 32'hA, 32'h10, 32'hDEADBEEF, 1'b0);
        do_op(SEL_MEM, 32'h2, 32'h10, 32'h0, 1'b0);
        do_op(SEL_MEM, 32'h2, 32'h10, 32'h0, 1'b0);
        do_op(SEL_NONE, 32'h2, 32'h10, 32'h0, 1'b0);
        do_op(SEL_NONE, 32'h0, 32'h77, 32'h0, 1'b0);

        do_op(SEL_MEM, 32'h0, 32'h13, 32'h0, 1'b0);
        do_op(SEL_MEM, 32'h4, 32'h13, 32'h0, 1'b0);
        do_op(SEL_MEM, 32'h1, 32'h12, 32'h0, 1'b0);
        do_op(SEL_MEM, 32'h5, 32'h12, 32'h0, 1'b0);

        do_op(SEL_MEM, 32'h8, 32'h11, 32'h55, 1'b0);
        do_op(SEL_MEM, 32'h2, 32'h10, 32'h0, 1'b0);

        do_op(SEL_MEM, 32'h2, 32'h21, 32'h0, 1'b0);
        do_op(SEL_MEM, 32'h9, 32'h33, 32'hAAAA, 1'b0);
        do_op(SEL_MEM, 32'h2, 32'h30, 32'h0, 1'b0);
        do_op(SEL_NONE, 32'h0, 32'h0, 32'h0, 1'b1);

        do_op(SEL_MEM, 32'hA, 32'h1004, 32'h12345678, 1'b0);
        do_op(SEL_MEM, 32'h2, 32'h4, 32'h0, 1'b0);
        do_op(SEL_MEM, 32'h2, 32'h4, 32'h0, 1'b1);

        for (int i = 0; i < 2000; i++) begin
            r    = $urandom_range(0, 9);
            sel  = (r < 8) ? SEL_MEM : ((r == 8) ? SEL_NONE : 3'd5);
            size = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ctrl = {28'($urandom), 1'($urandom), 1'($urandom), size};
            a    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, BYTES - 1));
            if ($urandom_range(0, 3) != 0) begin
                if (size == 2'd1) a[0] = 1'b0;
                if (size == 2'd2) a[1:0] = 2'b00;
            end
            do_op(sel, ctrl, a, $urandom, ($urandom_range(0, 7) == 0));
        end

        // Reset while a fetch of 0xCAFEF00D is in flight; the write under reset must not land.
        do_op(SEL_MEM, 32'hA, 32'h40, 32'hCAFEF00D, 1'b1);
        do_op(SEL_MEM, 32'h2, 32'h40, 32'h0, 1'b0);
        unit_sel  = SEL_MEM;
        unit_ctrl = 32'h2;
        addr      = 32'h40;
        fault_clr = 1'b0;
        op_id++;
        model_step(SEL_MEM, 32'h2, 32'h40, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_step(SEL_MEM, 32'h2, 32'h40, 32'h0, 1'b0);
        q.push_back('{rdata: m_rdata, fault: m_fault, faddr: m_faddr, id: op_id});
        do_op(SEL_MEM, 32'hA, 32'h40, 32'h11111111, 1'b0);
        rst = 1'b0;
        do_op(SEL_MEM, 32'h2, 32'h40, 32'h0, 1'b0);
        do_op(SEL_MEM, 32'h2, 32'h40, 32'h0, 1'b0);
        do_op(SEL_NONE, 32'h0, 32'h0, 32'h0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", op_id, 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
